stream_unpack: RTL
==================

Name: stream_unpack

Overview:
- Width down-converter for valid/ready streams.
- Accepts one wide word of RATIO×NARROW bits and emits it as RATIO narrow beats, least-significant beat first.
- Sits on the read side of a wide sync_fifo and feeds a narrow consumer (UART TX, byte-wide bus master).
- Sustains one narrow beat per cycle with no bubble between consecutive wide words.

Parameters:
- NARROW, 8, output beat width in bits.
- RATIO, 4, narrow beats per wide word; must be ≥2 and a power of two.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  NARROW*RATIO  wide word; beat k is in_data[k*NARROW +: NARROW].
- in_valid  in  1  upstream has a word.
- in_ready  out  1  block accepts a word this cycle.
- out_data  out  NARROW  current narrow beat.
- out_valid  out  1  out_data is valid.
- out_last  out  1  current beat is the final beat of its word.
- out_ready  in  1  downstream accepts the beat.

Behaviour:
- Reset/clock: one clock, clk; reset is asynchronous and active-low, rst_n.
- While rst_n is low:
  - out_valid=0, out_last=0, out_data=0, beat counter=0, state=IDLE.
  - in_ready is forced to 0 combinationally.
- Release of rst_n is synchronised by the integrator; the block takes no action on it.
- Transfer definitions:
  - Input transfer = in_valid & in_ready at a rising edge.
  - Output transfer = out_valid & out_ready at a rising edge.
- Storage:
  - Holding shift register, NARROW*RATIO bits.
  - Beat counter, log2(RATIO) bits.
  - Remaining-beat count, log2(RATIO) bits.
- States:
  - IDLE: out_valid=0.
    - in_ready = 1.
    - On input transfer: load holding register, counter=0, go to BUSY.
  - BUSY: out_valid=1, out_data = holding[NARROW-1:0], out_last = (remaining==0).
    - Output transfer, not last: shift holding right by NARROW, counter+1, remaining−1.
    - Output transfer on last beat, in_valid=1: load the new word in the same cycle and stay in BUSY (zero-bubble handoff).
    - Output transfer on last beat, in_valid=0: go to IDLE.
- in_ready is combinational: rst_n & (state==IDLE | (out_valid & out_ready & out_last)). There is no other path from in_valid to in_ready.
- Latency: beat 0 is visible on out_data the cycle after the input transfer.
- Stability: while out_valid & !out_ready, out_data and out_last hold their values; out_valid never deasserts without an output transfer.
- Throughput: with out_ready held high and in_valid held high, exactly one beat per cycle, out_last every RATIO-th cycle.
- Counter wrap: the counter wraps from RATIO-1 to 0 only when a new word loads; it never wraps mid-word.
- Simultaneous load and last-beat transfer: the last beat of the old word is consumed and beat 0 of the new word appears the next cycle.
- Reset mid-word: the partial word is discarded. No beat is emitted after rst_n rises until a new input transfer.

Optional Feature:
- Macro: STREAM_UNPACK_PARTIAL_EN.
- Defined:
  - Adds input port in_count (log2(RATIO) bits), the number of valid beats minus 1, sampled with in_data on the input transfer.
  - Remaining-beat count loads from in_count.
  - out_last asserts on beat in_count; higher beats are dropped without being presented.
- Not defined:
  - No in_count port.
  - Remaining count loads RATIO-1; every word emits exactly RATIO beats.

Test Plan:
1. Reset then single word: rst_n low 3 cycles, then in_data=32'hDDCCBBAA, out_ready=1 → beats AA,BB,CC,DD on 4 consecutive cycles starting 1 cycle after accept; out_last only with DD; in_ready=0 during AA..CC.
2. Back-to-back: words 32'h03020100 then 32'h07060504 with in_valid held, out_ready=1 → 8 contiguous beats 00..07, no gap cycle; second word accepted on the DD-position (03) cycle.
3. Backpressure: out_ready toggles 1,0,0,1,… on word 32'h44332211 → each beat held stable across stall cycles; sequence 11,22,33,44 with no drops or duplicates.
4. Reset mid-word: assert rst_n low after beat BB of 32'hDDCCBBAA → out_valid=0 immediately (asynchronous); after release, no output until the next word is accepted; next word 32'h0000_0055 emits 55,00,00,00.
5. Random soak: 1000 random words, random in_valid/out_ready at 50% → scoreboard confirms beat order and out_last placement; no beat lost or duplicated.
6. With STREAM_UNPACK_PARTIAL_EN: in_data=32'hDDCCBBAA, in_count=1 → beats AA,BB only, out_last on BB; in_ready high the same cycle BB transfers.

Source files
------------

// File: rtl/stream_unpack.sv
// stream_unpack: splits each wide valid/ready word into RATIO narrow beats, least-significant beat first.
// Define STREAM_UNPACK_PARTIAL_EN to add in_count, which lets a word carry fewer than RATIO beats.
module stream_unpack #(
    parameter int NARROW = 8,
    parameter int RATIO = 4,
    localparam int CW = $clog2(RATIO)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NARROW*RATIO-1:0]  in_data,
`ifdef STREAM_UNPACK_PARTIAL_EN
    input  logic [CW-1:0]            in_count,
`endif
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NARROW-1:0]        out_data,
    output logic                     out_valid,
    output logic                     out_last,
    input  logic                     out_ready
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state;
    logic [NARROW*RATIO-1:0] holding;
    logic [CW-1:0] cnt, rem, load_rem;
    logic load;
`ifdef STREAM_UNPACK_PARTIAL_EN
    assign load_rem = in_count;
`else
    assign load_rem = CW'(RATIO - 1);
`endif
    assign out_valid = state == BUSY;
    assign out_data  = holding[NARROW-1:0];
    assign out_last  = out_valid & (rem == '0);
    // A word can load in the same cycle the previous word's last beat leaves.
    assign in_ready  = rst_n & (state == IDLE | (out_valid & out_ready & out_last));
    assign load      = in_valid & in_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            holding <= '0;
            cnt     <= '0;
            rem     <= '0;
        end else if (load) begin
            state   <= BUSY;
            holding <= in_data;
            cnt     <= '0;
            rem     <= load_rem;
        end else if (out_valid & out_ready) begin
            if (out_last) begin
                state <= IDLE;
            end else begin
                holding <= holding >> NARROW;
                cnt     <= cnt + CW'(1);
                rem     <= rem - CW'(1);
            end
        end
    end
endmodule
